rvfi_mem_responder: RTL and testbench

//  Parametrised, synthesisable memory-response model for the core's req/gnt buses, driven by nondet inputs.

---
 rtl/rvfi_mem_pkg.sv | 26 ++
 rtl/rvfi_mem_chan_ctrl.sv | 82 ++++++++
 rtl/rvfi_mem_responder.sv | 99 +++++++++
 tb/tb_rvfi_mem_responder.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_mem_pkg.sv
// Shared types for the rvfi memory responder: per-channel state, latched request fields, index-width helper.
// Struct field widths are fixed here; the top's ADDR_W/DATA_W must match these package constants.
package rvfi_mem_pkg;

    localparam int PKG_ADDR_W = 64;
    localparam int PKG_DATA_W = 64;
    localparam int PKG_STRB_W = PKG_DATA_W / 8;

    typedef enum logic {
        IDLE,
        WAIT
    } chan_state_e;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        logic                  wen;
        logic [PKG_STRB_W-1:0] strb;
        logic [PKG_DATA_W-1:0] wdata;
    } req_t;

    // Width of a field that selects one of n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rvfi_mem_chan_ctrl.sv
// Per-channel tracker: IDLE/WAIT FSM, stall counter, request latch and sticky protocol check.
// Grant is combinational in the req cycle; a request still pending after MAX_STALL-1 stalls is force-granted.
module rvfi_mem_chan_ctrl
    import rvfi_mem_pkg::*;
#(
    parameter int MAX_STALL = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_req,
    input  req_t i_cur,
    input  logic i_nd_gnt,
    output logic o_gnt,
    output logic o_proto_err
);

    localparam int CNT_W = $clog2(MAX_STALL + 1);

    chan_state_e      r_state;
    chan_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_nxt;
    req_t             r_lat;
    logic             r_proto_err;
    logic             w_proto_nxt;
    logic             w_latch;
    logic             w_force;

    assign w_force     = (r_stall_cnt == CNT_W'(MAX_STALL - 1));
    assign o_gnt       = i_req & ~reset & (i_nd_gnt | w_force);
    assign o_proto_err = r_proto_err;

    always_comb begin
        w_state_nxt = r_state;
        w_stall_nxt = r_stall_cnt;
        w_proto_nxt = r_proto_err;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req && !o_gnt) begin
                    w_state_nxt = WAIT;
                    w_stall_nxt = CNT_W'(1);
                    w_latch     = 1'b1;
                end
            end
            WAIT: begin
                // A pending request must hold every field stable until granted.
                if (!i_req || (i_cur != r_lat)) begin
                    w_proto_nxt = 1'b1;
                    w_state_nxt = IDLE;
                    w_stall_nxt = '0;
                end else if (o_gnt) begin
                    w_state_nxt = IDLE;
                    w_stall_nxt = '0;
                end else begin
                    w_stall_nxt = r_stall_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_stall_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_stall_cnt <= '0;
            r_proto_err <= 1'b0;
            r_lat       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_nxt;
            r_proto_err <= w_proto_nxt;
            if (w_latch) begin
                r_lat <= i_cur;
            end
        end
    end

endmodule

// File: rtl/rvfi_mem_responder.sv
// Memory-response model for NCH req/gnt channels: bounded stall, word-coherent store, sticky protocol flags.
// Zero-latency response in the grant cycle; RVFI_MEM_ERR_INJECT_EN enables nondet error responses.
module rvfi_mem_responder
    import rvfi_mem_pkg::*;
#(
    parameter  int NCH       = 2,
    parameter  int ADDR_W    = PKG_ADDR_W,
    parameter  int DATA_W    = PKG_DATA_W,
    parameter  int DEPTH     = 16,
    parameter  int MAX_STALL = 4,
    parameter  int COHERENT  = 1,
    localparam int STRB_W    = DATA_W / 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NCH-1:0]        req,
    input  logic [NCH*ADDR_W-1:0] addr,
    input  logic [NCH-1:0]        wen,
    input  logic [NCH*STRB_W-1:0] strb,
    input  logic [NCH*DATA_W-1:0] wdata,
    output logic [NCH-1:0]        gnt,
    output logic [NCH-1:0]        err,
    output logic [NCH*DATA_W-1:0] rdata,
    input  logic [NCH-1:0]        nd_gnt,
    input  logic [NCH-1:0]        nd_err,
    input  logic [NCH*DATA_W-1:0] nd_rdata,
    output logic [NCH-1:0]        proto_err
);

    localparam int IDX_LSB = $clog2(STRB_W);
    localparam int IDX_W   = idx_w(DEPTH);

    logic [DATA_W-1:0] r_store [DEPTH];
    logic [NCH-1:0]    w_gnt;
    logic [NCH-1:0]    w_err;
    logic [NCH-1:0]    w_commit;
    logic [IDX_W-1:0]  w_idx [NCH];

`ifdef RVFI_MEM_ERR_INJECT_EN
    assign w_err = w_gnt & nd_err;
`else
    logic w_unused_nd_err;
    assign w_err           = '0;
    assign w_unused_nd_err = ^nd_err;
`endif

    assign gnt      = w_gnt;
    assign err      = w_err;
    assign w_commit = w_gnt & wen & ~w_err;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        req_t w_cur;

        assign w_cur = '{
            addr:  addr[c*ADDR_W +: ADDR_W],
            wen:   wen[c],
            strb:  strb[c*STRB_W +: STRB_W],
            wdata: wdata[c*DATA_W +: DATA_W]
        };
        assign w_idx[c] = addr[c*ADDR_W + IDX_LSB +: IDX_W];

        rvfi_mem_chan_ctrl #(
            .MAX_STALL (MAX_STALL)
        ) u_ctrl (
            .clock       (clock),
            .reset       (reset),
            .i_req       (req[c]),
            .i_cur       (w_cur),
            .i_nd_gnt    (nd_gnt[c]),
            .o_gnt       (w_gnt[c]),
            .o_proto_err (proto_err[c])
        );

        // Reads see the store before this cycle's writes land.
        assign rdata[c*DATA_W +: DATA_W] = (w_gnt[c] && !wen[c] && !w_err[c])
            ? ((COHERENT != 0) ? r_store[w_idx[c]] : nd_rdata[c*DATA_W +: DATA_W])
            : '0;
    end

    // Ascending channel order: the highest-numbered writer of a lane takes effect.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (COHERENT != 0) begin
                for (int d = 0; d < DEPTH; d++) begin
                    r_store[d] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (w_commit[c] && strb[c*STRB_W + b]) begin
                        r_store[w_idx[c]][b*8 +: 8] <= wdata[c*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rvfi_mem_responder.sv
// Self-checking bench for rvfi_mem_responder: directed scenarios plus randomized traffic against a transaction-level model.
module tb_rvfi_mem_responder;

    localparam int NCH       = 2;
    localparam int DEPTH     = 16;
    localparam int MAX_STALL = 4;
`ifdef RVFI_MEM_ERR_INJECT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic           clock;
    logic           reset;
    logic [1:0]     req;
    logic [127:0]   addr;
    logic [1:0]     wen;
    logic [15:0]    strb;
    logic [127:0]   wdata;
    logic [1:0]     gnt;
    logic [1:0]     err;
    logic [127:0]   rdata;
    logic [1:0]     nd_gnt;
    logic [1:0]     nd_err;
    logic [127:0]   nd_rdata;
    logic [1:0]     proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: memory contents, and per channel an in-flight transaction with its cycles-waited count.
    logic [63:0] m_mem [DEPTH];
    bit          m_pend [NCH];
    int          m_wait [NCH];
    logic [63:0] m_addr [NCH];
    logic        m_wen [NCH];
    logic [7:0]  m_strb [NCH];
    logic [63:0] m_wdata [NCH];
    bit          m_perr [NCH];
    logic        e_gnt [NCH];
    logic        e_err [NCH];
    logic [63:0] e_rdata [NCH];

    rvfi_mem_responder #(
        .NCH       (NCH),
        .ADDR_W    (64),
        .DATA_W    (64),
        .DEPTH     (DEPTH),
        .MAX_STALL (MAX_STALL),
        .COHERENT  (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .addr      (addr),
        .wen       (wen),
        .strb      (strb),
        .wdata     (wdata),
        .gnt       (gnt),
        .err       (err),
        .rdata     (rdata),
        .nd_gnt    (nd_gnt),
        .nd_err    (nd_err),
        .nd_rdata  (nd_rdata),
        .proto_err (proto_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] ch_addr(input int c);
        return addr[c*64 +: 64];
    endfunction

    function automatic logic [63:0] ch_wdata(input int c);
        return wdata[c*64 +: 64];
    endfunction

    function automatic logic [63:0] ch_rdata(input int c);
        return rdata[c*64 +: 64];
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        return int'((a / 64'd8) % 64'(DEPTH));
    endfunction

    task automatic idle_inputs();
        req      = '0;
        addr     = '0;
        wen      = '0;
        strb     = '0;
        wdata    = '0;
        nd_gnt   = '0;
        nd_err   = '0;
        nd_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic set_ch(input int c, input logic r, input logic [63:0] a, input logic w,
                          input logic [7:0] s, input logic [63:0] d);
        req[c]            = r;
        addr[c*64 +: 64]  = a;
        wen[c]            = w;
        strb[c*8 +: 8]    = s;
        wdata[c*64 +: 64] = d;
    endtask

    task automatic model_expect();
        for (int c = 0; c < NCH; c++) begin
            int waited;
            waited     = m_pend[c] ? m_wait[c] : 0;
            e_gnt[c]   = !reset && req[c] && (nd_gnt[c] || waited == MAX_STALL - 1);
            e_err[c]   = ERR_EN && e_gnt[c] && nd_err[c];
            e_rdata[c] = (e_gnt[c] && !wen[c] && !e_err[c]) ? m_mem[idx_of(ch_addr(c))] : 64'h0;
        end
    endtask

    task automatic model_commit();
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            for (int c = 0; c < NCH; c++) begin
                m_pend[c] = 0;
                m_wait[c] = 0;
                m_perr[c] = 0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (e_gnt[c] && wen[c] && !e_err[c]) begin
                    for (int b = 0; b < 8; b++) begin
                        if (strb[c*8 + b]) m_mem[idx_of(ch_addr(c))][b*8 +: 8] = ch_wdata(c)[b*8 +: 8];
                    end
                end
            end
            for (int c = 0; c < NCH; c++) begin
                bit same;
                same = (m_addr[c] == ch_addr(c)) && (m_wen[c] == wen[c]) &&
                       (m_strb[c] == strb[c*8 +: 8]) && (m_wdata[c] == ch_wdata(c));
                if (m_pend[c]) begin
                    if (!req[c] || !same) begin
                        m_perr[c] = 1;
                        m_pend[c] = 0;
                    end else if (e_gnt[c]) begin
                        m_pend[c] = 0;
                    end else begin
                        m_wait[c]++;
                    end
                end else if (req[c] && !e_gnt[c]) begin
                    m_pend[c]  = 1;
                    m_wait[c]  = 1;
                    m_addr[c]  = ch_addr(c);
                    m_wen[c]   = wen[c];
                    m_strb[c]  = strb[c*8 +: 8];
                    m_wdata[c] = ch_wdata(c);
                end
            end
        end
    endtask

    // Inputs are driven at the falling edge; outputs are sampled 1 time unit later.
    task automatic settle();
        #1;
        model_expect();
    endtask

    task automatic advance();
        model_commit();
        @(negedge clock);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset  = 1'b1;
        req    = 2'b11;
        nd_gnt = 2'b11;
        settle();
        n_checks++;
        if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        n_checks++;
        if (proto_err !== 2'b00) begin n_fail++; $display("FAIL reset_proto: got %b expected 00", proto_err); end
        n_checks++;
        if (rdata !== 128'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        advance();
        reset = 1'b0;
        idle_inputs();
        settle();
        n_checks++;
        if (gnt !== 2'b00) begin n_fail++; $display("FAIL idle_gnt: got %b expected 00", gnt); end
        advance();
    endtask

    task automatic test_stall_bound();
        idle_inputs();
        set_ch(0, 1'b1, 64'h20, 1'b0, 8'h00, 64'h0);
        // Two held transactions back to back: each must take exactly MAX_STALL cycles.
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < MAX_STALL; i++) begin
                settle();
                n_checks++;
                if (gnt[0] !== logic'(i == MAX_STALL - 1)) begin
                    n_fail++;
                    $display("FAIL stall_bound t%0d cyc%0d: got %b expected %b", t, i, gnt[0], i == MAX_STALL - 1);
                end
                advance();
            end
        end
        idle_inputs();
        settle();
        n_checks++;
        if (proto_err !== 2'b00) begin n_fail++; $display("FAIL stall_proto: got %b expected 00", proto_err); end
        advance();
    endtask

    task automatic test_write_merge();
        idle_inputs();
        nd_gnt = 2'b10;
        set_ch(1, 1'b1, 64'h40, 1'b1, 8'h0F, 64'h1122334455667788);
        settle();
        n_checks++;
        if (gnt[1] !== 1'b1) begin n_fail++; $display("FAIL merge_wgnt: got %b expected 1", gnt[1]); end
        advance();
        set_ch(1, 1'b1, 64'h40, 1'b0, 8'h00, 64'h0);
        settle();
        n_checks++;
        if (ch_rdata(1) !== 64'h0000000055667788) begin
            n_fail++; $display("FAIL merge_read: got %h expected 0000000055667788", ch_rdata(1));
        end
        advance();
    endtask

    task automatic test_collision();
        idle_inputs();
        nd_gnt = 2'b11;
        // ch1 reaches index 2 through wrapped high bits and misaligned low bits.
        set_ch(0, 1'b1, 64'h10, 1'b1, 8'hFF, 64'hAAAAAAAAAAAAAAAA);
        set_ch(1, 1'b1, 64'hFFFF000000000093, 1'b1, 8'hFF, 64'hBBBBBBBBBBBBBBBB);
        settle();
        n_checks++;
        if (gnt !== 2'b11) begin n_fail++; $display("FAIL coll_gnt: got %b expected 11", gnt); end
        advance();
        idle_inputs();
        nd_gnt = 2'b11;
        set_ch(0, 1'b1, 64'h10, 1'b0, 8'h00, 64'h0);
        settle();
        n_checks++;
        if (ch_rdata(0) !== 64'hBBBBBBBBBBBBBBBB) begin
            n_fail++; $display("FAIL coll_winner: got %h expected bbbbbbbbbbbbbbbb", ch_rdata(0));
        end
        advance();
        set_ch(0, 1'b1, 64'h28, 1'b1, 8'hFF, 64'h1111111111111111);
        set_ch(1, 1'b1, 64'h28, 1'b0, 8'h00, 64'h0);
        settle();
        n_checks++;
        if (ch_rdata(1) !== 64'h0) begin n_fail++; $display("FAIL coll_old_read: got %h expected 0", ch_rdata(1)); end
        advance();
        set_ch(0, 1'b0, 64'h0, 1'b0, 8'h00, 64'h0);
        settle();
        n_checks++;
        if (ch_rdata(1) !== 64'h1111111111111111) begin
            n_fail++; $display("FAIL coll_new_read: got %h expected 1111111111111111", ch_rdata(1));
        end
        advance();
    endtask

    task automatic test_proto_err();
        idle_inputs();
        set_ch(0, 1'b1, 64'h100, 1'b0, 8'h00, 64'h0);
        settle();
        n_checks++;
        if (gnt[0] !== 1'b0) begin n_fail++; $display("FAIL proto_first_gnt: got %b expected 0", gnt[0]); end
        advance();
        set_ch(0, 1'b1, 64'h108, 1'b0, 8'h00, 64'h0);
        settle();
        n_checks++;
        if (proto_err[0] !== 1'b0) begin n_fail++; $display("FAIL proto_early: got %b expected 0", proto_err[0]); end
        advance();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            settle();
            n_checks++;
            if (proto_err !== 2'b01) begin
                n_fail++; $display("FAIL proto_sticky cyc%0d: got %b expected 01", i, proto_err);
            end
            advance();
        end
    endtask

    task automatic test_err_inject();
        logic [63:0] exp_rd;
        idle_inputs();
        nd_gnt = 2'b01;
        nd_err = 2'b01;
        set_ch(0, 1'b1, 64'h18, 1'b1, 8'hFF, 64'hDEAD);
        settle();
        n_checks++;
        if (err[0] !== ERR_EN) begin n_fail++; $display("FAIL err_flag: got %b expected %b", err[0], ERR_EN); end
        advance();
        nd_err = 2'b00;
        set_ch(0, 1'b1, 64'h18, 1'b0, 8'h00, 64'h0);
        settle();
        exp_rd = ERR_EN ? 64'h0 : 64'hDEAD;
        n_checks++;
        if (ch_rdata(0) !== exp_rd) begin n_fail++; $display("FAIL err_store: got %h expected %h", ch_rdata(0), exp_rd); end
        advance();
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        set_ch(1, 1'b1, 64'h0, 1'b1, 8'hFF, 64'h5A5A5A5A5A5A5A5A);
        settle();
        advance();
        reset  = 1'b1;
        nd_gnt = 2'b11;
        settle();
        n_checks++;
        if (gnt !== 2'b00) begin n_fail++; $display("FAIL rstwait_gnt: got %b expected 00", gnt); end
        advance();
        reset = 1'b0;
        idle_inputs();
        settle();
        n_checks++;
        if (proto_err !== 2'b00) begin n_fail++; $display("FAIL rstwait_proto: got %b expected 00", proto_err); end
        advance();
        nd_gnt = 2'b11;
        set_ch(0, 1'b1, 64'h0, 1'b0, 8'h00, 64'h0);
        set_ch(1, 1'b1, 64'h10, 1'b0, 8'h00, 64'h0);
        settle();
        n_checks++;
        if (ch_rdata(0) !== 64'h0) begin n_fail++; $display("FAIL rstwait_addr0: got %h expected 0", ch_rdata(0)); end
        n_checks++;
        if (ch_rdata(1) !== 64'h0) begin n_fail++; $display("FAIL rstwait_cleared: got %h expected 0", ch_rdata(1)); end
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 99) == 0);
            nd_gnt   = {($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4)};
            nd_err   = 2'($urandom);
            nd_rdata = {$urandom, $urandom, $urandom, $urandom};
            for (int c = 0; c < NCH; c++) begin
                if (!m_pend[c] || $urandom_range(0, 19) == 0) begin
                    set_ch(c, ($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom),
                           8'($urandom), {$urandom, $urandom});
                end
            end
            settle();
            for (int c = 0; c < NCH; c++) begin
                n_checks++;
                if (gnt[c] !== e_gnt[c]) begin
                    n_fail++; $display("FAIL rnd_gnt n%0d ch%0d: got %b expected %b", n, c, gnt[c], e_gnt[c]);
                end
                n_checks++;
                if (err[c] !== e_err[c]) begin
                    n_fail++; $display("FAIL rnd_err n%0d ch%0d: got %b expected %b", n, c, err[c], e_err[c]);
                end
                n_checks++;
                if (ch_rdata(c) !== e_rdata[c]) begin
                    n_fail++; $display("FAIL rnd_rdata n%0d ch%0d: got %h expected %h", n, c, ch_rdata(c), e_rdata[c]);
                end
                n_checks++;
                if (proto_err[c] !== logic'(m_perr[c])) begin
                    n_fail++; $display("FAIL rnd_proto n%0d ch%0d: got %b expected %b", n, c, proto_err[c], m_perr[c]);
                end
            end
            advance();
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            m_pend[c]  = 0;
            m_wait[c]  = 0;
            m_perr[c]  = 0;
            m_addr[c]  = '0;
            m_wen[c]   = 1'b0;
            m_strb[c]  = '0;
            m_wdata[c] = '0;
        end
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        @(negedge clock);
        test_reset();
        test_stall_bound();
        test_write_merge();
        test_collision();
        test_proto_err();
        test_err_inject();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
